// File: rtl/dqn_pkg.sv
// Shared DQN fixed-point types: FSM state encoding, Q16.16 limits and saturation.
package dqn_pkg;

  typedef enum logic [2:0] {IDLE, READ_TGT, CALC, WRITE, DONE} state_t;

  localparam int FRAC_BITS_DEFAULT = 16;
  localparam int FIX_W             = 32;

  localparam logic [FIX_W-1:0] MAX_FIX = 32'h7FFF_FFFF;
  localparam logic [FIX_W-1:0] MIN_FIX = 32'h8000_0000;

  // In range when every bit from the sign of the narrow result upward agrees.
  function automatic logic [FIX_W-1:0] saturate(input logic [2*FIX_W:0] v);
    logic [FIX_W+1:0] top;
    top = v[2*FIX_W:FIX_W-1];
    if (top == {(FIX_W+2){1'b0}} || top == {(FIX_W+2){1'b1}}) begin
      return v[FIX_W-1:0];
    end
    return v[2*FIX_W] ? MIN_FIX : MAX_FIX;
  endfunction

endpackage

// File: rtl/fixed_mul_add_sat.sv
// Combinational y = sat((a*b >>> FRAC_BITS) + c); the shift floors toward -inf.
module fixed_mul_add_sat #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16
) (
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic [DATA_WIDTH-1:0] i_c,
  output logic [DATA_WIDTH-1:0] o_y
);
  import dqn_pkg::*;

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [2*DATA_WIDTH-1:0] shifted;
  logic signed [2*DATA_WIDTH:0]   sum;

  always_comb begin
    prod    = $signed(i_a) * $signed(i_b);
    shifted = prod >>> FRAC_BITS;
    sum     = (2*DATA_WIDTH+1)'(shifted) + (2*DATA_WIDTH+1)'($signed(i_c));
    o_y     = saturate(sum);
  end

endmodule

// File: rtl/q_target_expected_generator.sv
// DQN target builder: max over target-net Q, y = r + gamma*max (or r if terminal),
// then copies main-net outputs to the expected RAM with y at the taken action.
module q_target_expected_generator #(
  parameter int DATA_WIDTH            = 32,
  parameter int FRAC_BITS             = 16,
  parameter int ADDRESS_WIDTH         = 11,
  parameter int NUMBER_OF_OUTPUT_NODE = 3,
  parameter int TARGET_BASE           = 0,
  parameter int MAIN_BASE             = 0,
  parameter int EXPECTED_BASE         = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_valid,
  input  logic [DATA_WIDTH-1:0]    i_reward,
  input  logic [DATA_WIDTH-1:0]    i_gamma,
  input  logic                     i_done,
  input  logic [7:0]               i_action,
  output logic [ADDRESS_WIDTH-1:0] o_tgt_rd_addr,
  input  logic [DATA_WIDTH-1:0]    i_tgt_rd_data,
  output logic [ADDRESS_WIDTH-1:0] o_main_rd_addr,
  input  logic [DATA_WIDTH-1:0]    i_main_rd_data,
  output logic                     o_exp_wr_en,
  output logic [ADDRESS_WIDTH-1:0] o_exp_wr_addr,
  output logic [DATA_WIDTH-1:0]    o_exp_wr_data,
  output logic                     o_action_err,
  output logic                     o_valid
);
  import dqn_pkg::*;

  localparam int N  = NUMBER_OF_OUTPUT_NODE;
  localparam int CW = $clog2(N + 1);

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   reward_q, reward_d;
  logic [DATA_WIDTH-1:0]   gamma_q, gamma_d;
  logic                    done_q, done_d;
  logic [7:0]              action_q, action_d;
  logic [DATA_WIDTH-1:0]   max_q, max_d;
  logic [DATA_WIDTH-1:0]   y_q, y_d;
  logic                    err_q, err_d;
  logic [ADDRESS_WIDTH-1:0] tgt_addr_q, tgt_addr_d;
  logic [ADDRESS_WIDTH-1:0] main_addr_q, main_addr_d;

  logic [DATA_WIDTH-1:0]   mac_y;
  logic                    last_cnt;
  logic                    wr_act;
  logic [7:0]              wr_idx;

  fixed_mul_add_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS)
  ) u_mac (
    .i_a (gamma_q),
    .i_b (max_q),
    .i_c (reward_q),
    .o_y (mac_y)
  );

  assign last_cnt = (cnt_q == CW'(N));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    reward_d    = reward_q;
    gamma_d     = gamma_q;
    done_d      = done_q;
    action_d    = action_q;
    max_d       = max_q;
    y_d         = y_q;
    err_d       = err_q;
    tgt_addr_d  = tgt_addr_q;
    main_addr_d = main_addr_q;

    case (state_q)
      IDLE: begin
        if (i_valid) begin
          reward_d   = i_reward;
          gamma_d    = i_gamma;
          done_d     = i_done;
          action_d   = i_action;
          err_d      = 1'b0;
          cnt_d      = '0;
          tgt_addr_d = ADDRESS_WIDTH'(TARGET_BASE);
          state_d    = READ_TGT;
        end
      end
      READ_TGT: begin
        // Data for address cnt-1 arrives while cnt is shown; first sample seeds the max.
        if (cnt_q != '0) begin
          if (cnt_q == CW'(1) || $signed(i_tgt_rd_data) > $signed(max_q)) begin
            max_d = i_tgt_rd_data;
          end
        end
        if (cnt_q < CW'(N - 1)) begin
          tgt_addr_d = tgt_addr_q + ADDRESS_WIDTH'(1);
        end
        if (last_cnt) begin
          cnt_d   = '0;
          state_d = CALC;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      CALC: begin
        y_d         = done_q ? reward_q : mac_y;
        err_d       = (action_q >= 8'(N));
        main_addr_d = ADDRESS_WIDTH'(MAIN_BASE);
        state_d     = WRITE;
      end
      WRITE: begin
        if (cnt_q < CW'(N - 1)) begin
          main_addr_d = main_addr_q + ADDRESS_WIDTH'(1);
        end
        if (last_cnt) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      reward_q    <= '0;
      gamma_q     <= '0;
      done_q      <= 1'b0;
      action_q    <= '0;
      max_q       <= '0;
      y_q         <= '0;
      err_q       <= 1'b0;
      tgt_addr_q  <= '0;
      main_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      reward_q    <= reward_d;
      gamma_q     <= gamma_d;
      done_q      <= done_d;
      action_q    <= action_d;
      max_q       <= max_d;
      y_q         <= y_d;
      err_q       <= err_d;
      tgt_addr_q  <= tgt_addr_d;
      main_addr_q <= main_addr_d;
    end
  end

  // Writes trail the main reads by one cycle, so node index is cnt-1.
  always_comb begin
    wr_act        = (state_q == WRITE) && (cnt_q != '0);
    wr_idx        = 8'(cnt_q) - 8'd1;
    o_exp_wr_en   = wr_act;
    o_exp_wr_addr = '0;
    o_exp_wr_data = '0;
    if (wr_act) begin
      o_exp_wr_addr = ADDRESS_WIDTH'(EXPECTED_BASE) + ADDRESS_WIDTH'(wr_idx);
      o_exp_wr_data = (wr_idx == action_q) ? y_q : i_main_rd_data;
    end
  end

  assign o_tgt_rd_addr  = tgt_addr_q;
  assign o_main_rd_addr = main_addr_q;
  assign o_action_err   = err_q;
  assign o_valid        = (state_q == DONE);

endmodule

// File: doc/q_target_expected_generator.md
# q_target_expected_generator

Computes the DQN training target for one transition and writes the expected-output vector consumed by `back_propagation_output_layer`. It reads the target-network Q-values and finds their maximum. It forms y = reward + gamma·max, or y = reward on a terminal transition. It then writes, for every output node, the main-network output unchanged except at the taken action, which gets y. It sits directly upstream of output-layer back-propagation, and its o_valid is the trigger for that block's i_valid.

## Interface
- DATA_WIDTH, 32: signed fixed-point word width.
- FRAC_BITS, 16: fractional bits; codebase format is Q16.16.
- ADDRESS_WIDTH, 11: RAM address width.
- NUMBER_OF_OUTPUT_NODE, 3: Q-values per state, N.
- TARGET_BASE, 0: target-network output RAM base address.
- MAIN_BASE, 0: main-network output RAM base address.
- EXPECTED_BASE, 0: expected RAM base address.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  start pulse; sampled only in IDLE.
- i_reward  in  DATA_WIDTH  signed reward.
- i_gamma  in  DATA_WIDTH  discount factor, signed Q format.
- i_done  in  1  terminal transition.
- i_action  in  8  action index taken.
- o_tgt_rd_addr  out  ADDRESS_WIDTH  target RAM read address.
- i_tgt_rd_data  in  DATA_WIDTH  target RAM data, 1-cycle read latency.
- o_main_rd_addr  out  ADDRESS_WIDTH  main output RAM read address.
- i_main_rd_data  in  DATA_WIDTH  main RAM data, 1-cycle latency.
- o_exp_wr_en  out  1  expected RAM write strobe.
- o_exp_wr_addr  out  ADDRESS_WIDTH  expected RAM address.
- o_exp_wr_data  out  DATA_WIDTH  expected value.
- o_action_err  out  1  i_action ≥ N; held until the next accepted i_valid.
- o_valid  out  1  one-cycle done pulse.

## Operation
- **IDLE:** on i_valid, latch reward, gamma, done and action, clear o_action_err, and go to READ_TGT.
  - i_valid in any other state is ignored.
- **READ_TGT (N+1 cycles):** issue addresses TARGET_BASE+0..N-1 on consecutive cycles and capture data one cycle later.
  - Running signed max; the first sample initialises it; ties keep the earlier value.
  - Target reads are always performed, including when done=1.
- **CALC (1 cycle):**
  - prod = gamma·max as a 2·DATA_WIDTH signed product.
  - Arithmetic right shift by FRAC_BITS, which floors.
  - Add reward in 2·DATA_WIDTH+1 bits, then saturate to [0x8000_0000, 0x7FFF_FFFF].
  - done=1 gives y = reward exactly.
- **WRITE (N+1 cycles):** read MAIN_BASE+k; one cycle later write EXPECTED_BASE+k.
  - Data is y when k == action, otherwise i_main_rd_data.
  - Action ≥ N: every node is copied unchanged and o_action_err=1.
- **DONE (1 cycle):** o_valid=1, then return to IDLE.

## Timing
- Reset values: all outputs 0; state IDLE; internal registers 0.
- Latency: o_valid is high in the (2N+4)th cycle after the edge that sampled i_valid. For N=3 that is 10 cycles.
- The block is busy from that edge until o_valid. Back-to-back starts: i_valid in the cycle after o_valid is accepted.
- o_exp_wr_en is high for exactly N cycles per operation, with consecutive addresses and no gaps.
- Read addresses hold their last value when not reading; data is ignored outside the capture windows.
- Reset mid-operation: return to IDLE immediately. No further writes, o_valid is not asserted, and a partially written expected RAM is left as is.
- i_valid is a level sampled per cycle in IDLE; a multi-cycle pulse starts exactly one operation and then drops while the block is busy.

## Structure
- dqn_pkg holds:
  - the state enum (IDLE, READ_TGT, CALC, WRITE, DONE);
  - the FRAC_BITS default;
  - the saturation limits MAX_FIX and MIN_FIX;
  - the saturate function.
- One sub-module, `fixed_mul_add_sat`: combinational a·b>>>FRAC_BITS + c with saturation, registered by the parent in CALC.
- The FSM, address counters and max tracker stay in the top module.

## Test plan
- **Basic:** target [1.0, 3.0, 2.0], reward 1.0, gamma 0x8000, done 0, action 1, main [0x4000, 0x8000, 0xC000] → writes [0x00004000, 0x00028000, 0x0000C000] to addresses 0..2; o_valid in cycle 10.
- **Terminal:** same data with done=1 and reward 0xFFFF0000 → node 1 written 0xFFFF0000; the other nodes are unchanged.
- **Negative max:** target [-1.0, -3.0, -2.0], gamma 0x8000, reward 0, action 0 → node 0 = 0xFFFF8000.
- **Saturation:** reward 0x7FFF0000, gamma 0x10000, target all 0x7FFF0000 → y = 0x7FFFFFFF.
  - Repeat with negatives → y = 0x80000000.
- **Bad action:** action 5 → all three main values copied, o_action_err=1, o_valid still in cycle 10.
- **Robustness:**
  - i_valid re-pulsed during WRITE → ignored, exactly 3 writes.
  - rst_n low in cycle 7 → outputs 0 immediately, no o_valid.
  - A new i_valid after reset completes normally.
